// File: rtl/mem_bfm_arbiter.sv
// Round-robin arbiter placing NUM_REQS upstream requesters onto a single-ported
// memory BFM, one transaction in flight, with optional strict priority for port 0.
module mem_bfm_arbiter #(
  parameter int NUM_REQS       = 2,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 512,
  parameter int TAG_WIDTH      = 49,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           prio_load,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0]            req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic [NUM_REQS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic [NUM_REQS-1:0]            rsp_ready,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_data,
  output logic [TAG_WIDTH-1:0]           mem_req_tag,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]           mem_rsp_tag,
  output logic                           mem_rsp_ready,
  output logic                           busy,
  output logic [$clog2(NUM_REQS)-1:0]    owner,
  output logic                           err_timeout
);

  localparam int PTR_W   = $clog2(NUM_REQS);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [TIMER_W-1:0]     timer;
  logic                   hold_rw;
  logic [ADDR_WIDTH-1:0]  hold_addr;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic [TAG_WIDTH-1:0]   hold_tag;

  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQS];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQS];
  logic [TAG_WIDTH-1:0]   tag_arr  [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
  end

  logic             grant_valid;
  logic             prio_hit;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] rr_next;

  // Scan from the highest offset down so the port closest to rr_ptr wins last.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    winner      = '0;
    cand        = '0;
    prio_hit    = prio_load & req_valid[0];
    if (prio_hit) begin
      grant_valid = 1'b1;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQS);
        if (req_valid[cand]) begin
          grant_valid = 1'b1;
          winner      = cand;
        end
      end
    end
  end

  assign rr_next = (winner == PTR_W'(NUM_REQS - 1)) ? '0 : winner + PTR_W'(1);

  // The accept handshake is combinational; it is masked while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && state == IDLE && grant_valid) req_ready[winner] = 1'b1;
  end

  assign mem_req_rw   = hold_rw;
  assign mem_req_addr = hold_addr;
  assign mem_req_data = hold_data;
  assign mem_req_tag  = hold_tag;
  assign rsp_tag      = hold_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      timer         <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_rsp_ready <= 1'b0;
      rsp_valid     <= '0;
      // NOTE: the wide data/tag holds are reset too, so no stale line is visible on the buses after reset.
      hold_rw       <= 1'b0;
      hold_addr     <= '0;
      hold_data     <= '0;
      hold_tag      <= '0;
      rsp_data      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner         <= winner;
            hold_rw       <= req_rw[winner];
            hold_addr     <= addr_arr[winner];
            hold_data     <= data_arr[winner];
            hold_tag      <= tag_arr[winner];
            if (!prio_hit) rr_ptr <= rr_next;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (hold_rw) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              timer         <= '0;
              mem_rsp_ready <= 1'b1;
              state         <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            rsp_data         <= mem_rsp_data;
            mem_rsp_ready    <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout   <= 1'b1;
            mem_rsp_ready <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_req_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
  a_rsp_valid_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));
  a_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable({hold_rw, hold_addr, hold_data, hold_tag})));
  // The BFM's returned tag is only of debug interest; it must at least be driven.
  a_rsp_tag_known: assert property (@(posedge clk) disable iff (!reset_n)
    mem_rsp_valid |-> !$isunknown(mem_rsp_tag));

endmodule
